// File: rtl/medidor_hcsr04.sv
`timescale 1ns/1ps
// HC-SR04 ultrasonic range meter: trigger pulse, echo timing, rounded BCD distance in cm.
module medidor_hcsr04 #(
  parameter int unsigned CM_CYCLES      = 2941,
  parameter int unsigned HALF_CM        = 1470,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [2:0]  db_estado
);

  localparam int unsigned WAIT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int unsigned SUB_W    = $clog2(CM_CYCLES + 1);

  typedef enum logic [2:0] {
    INICIAL     = 3'd0,
    PREPARA     = 3'd1,
    TRIGGER     = 3'd2,
    ESPERA_ECHO = 3'd3,
    MEDE        = 3'd4,
    FINAL       = 3'd5
  } estado_t;

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [11:0]      bcd_q, bcd_d, bcd_inc_c;
  logic [11:0]      medida_q, medida_d;
  logic             trigger_q, trigger_d;
  logic             pronto_q, pronto_d;
  logic             timeout_q, timeout_d;
  logic             echo_m_q, echo_m_d;
  logic             echo_s_q, echo_s_d;
  logic             echo_p_q, echo_p_d;

  // Saturating three-digit BCD increment of the working counter.
  always_comb begin
    bcd_inc_c = bcd_q;
    if (bcd_q != 12'h999) begin
      if (bcd_q[3:0] != 4'd9) begin
        bcd_inc_c[3:0] = bcd_q[3:0] + 4'd1;
      end else begin
        bcd_inc_c[3:0] = 4'd0;
        if (bcd_q[7:4] != 4'd9) begin
          bcd_inc_c[7:4] = bcd_q[7:4] + 4'd1;
        end else begin
          bcd_inc_c[7:4]  = 4'd0;
          bcd_inc_c[11:8] = bcd_q[11:8] + 4'd1;
        end
      end
    end
  end

  // Next-state and registered-output logic; outputs are set on the edge entering their state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    bcd_d     = bcd_q;
    medida_d  = medida_q;
    timeout_d = timeout_q;
    trigger_d = 1'b0;
    pronto_d  = 1'b0;
    echo_m_d  = echo;
    echo_s_d  = echo_m_q;
    echo_p_d  = echo_s_q;

    case (state_q)
      INICIAL: begin
        if (medir) state_d = PREPARA;
      end
      PREPARA: begin
        cnt_d     = '0;
        sub_d     = '0;
        bcd_d     = 12'h000;
        trigger_d = 1'b1;
        state_d   = TRIGGER;
      end
      TRIGGER: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ESPERA_ECHO;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          trigger_d = 1'b1;
        end
      end
      ESPERA_ECHO: begin
        // A level already high on entry has echo_p_q set, so it never looks like a rise.
        if (echo_s_q && !echo_p_q) begin
          sub_d   = SUB_W'(HALF_CM);
          state_d = MEDE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          pronto_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEDE: begin
        if (echo_s_q) begin
          if (sub_q == SUB_W'(CM_CYCLES - 1)) begin
            sub_d = '0;
            bcd_d = bcd_inc_c;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end else begin
          pronto_d  = 1'b1;
          timeout_d = 1'b0;
          medida_d  = bcd_q;
          state_d   = FINAL;
        end
      end
      FINAL: begin
        state_d = INICIAL;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  // All state, including the echo synchroniser, with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= INICIAL;
      cnt_q     <= '0;
      sub_q     <= '0;
      bcd_q     <= 12'h000;
      medida_q  <= 12'h000;
      trigger_q <= 1'b0;
      pronto_q  <= 1'b0;
      timeout_q <= 1'b0;
      echo_m_q  <= 1'b0;
      echo_s_q  <= 1'b0;
      echo_p_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      bcd_q     <= bcd_d;
      medida_q  <= medida_d;
      trigger_q <= trigger_d;
      pronto_q  <= pronto_d;
      timeout_q <= timeout_d;
      echo_m_q  <= echo_m_d;
      echo_s_q  <= echo_s_d;
      echo_p_q  <= echo_p_d;
    end
  end

  assign trigger   = trigger_q;
  assign medida    = medida_q;
  assign pronto    = pronto_q;
  assign timeout   = timeout_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_medidor_hcsr04.sv
`timescale 1ns/1ps
// Bench for medidor_hcsr04 with shortened timing parameters.
module tb_medidor_hcsr04;

  localparam int CM   = 10;
  localparam int HALF = 5;
  localparam int TRIG = 5;
  localparam int TMO  = 300;

  logic        clock = 1'b0;
  logic        reset, medir, echo;
  logic        trigger, pronto, timeout;
  logic [11:0] medida;
  logic [2:0]  db_estado;

  int checks = 0;
  int failures = 0;
  int pronto_cnt = 0;
  int trig_rises = 0;
  int hold_viol = 0;
  int trig_viol = 0;
  logic        last_trig = 1'b0;
  logic [11:0] last_medida;
  logic        last_timeout;

  logic [11:0] exp_medida = 12'h000;
  logic        exp_timeout = 1'b0;

  medidor_hcsr04 #(
    .CM_CYCLES(CM), .HALF_CM(HALF), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo),
    .trigger(trigger), .medida(medida), .pronto(pronto),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Passive observer: pronto pulses, trigger rises, output-hold and trigger-state rules.
  always @(negedge clock) begin
    if (pronto === 1'b1) pronto_cnt++;
    if (trigger === 1'b1 && last_trig !== 1'b1) trig_rises++;
    last_trig = trigger;
    if (reset === 1'b0 && pronto !== 1'b1 &&
        (medida !== last_medida || timeout !== last_timeout)) hold_viol++;
    if (trigger === 1'b1 && db_estado !== 3'd2) trig_viol++;
    last_medida  = medida;
    last_timeout = timeout;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: nearest centimetre, half rounds up, clamped at 999, as three BCD digits.
  function automatic int model_cm(input int high_cycles);
    int cm;
    cm = (high_cycles + HALF) / CM;
    return (cm > 999) ? 999 : cm;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // The first synchronised high cycle is spent recognising the rise, so the count
  // sees one fewer cycle than the pin; keep widths off exact cm boundaries so
  // that one-cycle alignment cannot change the expected result.
  function automatic int safe_width(input int w);
    int r;
    r = w;
    while (((r + HALF) % CM) == 0) r++;
    return r;
  endfunction

  task automatic pulse_medir();
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
  endtask

  task automatic wait_trigger(input bit raise_echo);
    int n, wd;
    n = 0;
    while (trigger !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("trigger_start", 32'(n < 20), 32'd1);
    if (raise_echo) echo = 1'b1;
    wd = 0;
    while (trigger === 1'b1 && wd < TRIG + 20) begin wd++; @(negedge clock); end
    chk("trigger_width", 32'(wd), 32'(TRIG));
  endtask

  task automatic echo_pulse(input int w, input bit poke, output int lat);
    echo = 1'b1;
    for (int i = 0; i < w; i++) begin
      if (poke && w >= 8 && i == w / 2) medir = 1'b1;
      if (poke && w >= 8 && i == w / 2 + 1) medir = 1'b0;
      @(negedge clock);
    end
    medir = poke ? 1'b0 : medir;
    echo = 1'b0;
    lat = 0;
    while (pronto !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
  endtask

  task automatic result_check(input int w, input int lat, input int p0, input string tag);
    exp_medida  = to_bcd(model_cm(w - 1));
    exp_timeout = 1'b0;
    chk({tag, "_pronto_latency"}, 32'(lat >= 1 && lat <= 4), 32'd1);
    chk({tag, "_medida"}, 32'(medida), 32'(exp_medida));
    chk({tag, "_timeout"}, 32'(timeout), 32'(exp_timeout));
    repeat (2) @(negedge clock);
    #1;
    chk({tag, "_pronto_once"}, 32'(pronto_cnt - p0), 32'd1);
  endtask

  task automatic measure(input int w_in, input string tag);
    int w, lat, p0;
    w  = safe_width(w_in);
    p0 = pronto_cnt;
    pulse_medir();
    wait_trigger(1'b0);
    repeat ($urandom_range(0, 40)) @(negedge clock);
    echo_pulse(w, 1'b1, lat);
    result_check(w, lat, p0, tag);
    repeat (3) @(negedge clock);
    chk({tag, "_idle_after"}, 32'(db_estado), 32'd0);
  endtask

  task automatic no_echo(input bit echo_early, input string tag);
    int k, p0;
    p0 = pronto_cnt;
    pulse_medir();
    wait_trigger(echo_early);
    k = 0;
    while (pronto !== 1'b1 && k < TMO + 50) begin
      @(negedge clock);
      k++;
      if (k == 20) echo = 1'b0;
    end
    echo = 1'b0;
    exp_timeout = 1'b1;
    chk({tag, "_latency"}, 32'(k), 32'(TMO));
    chk({tag, "_flag"}, 32'(timeout), 32'(exp_timeout));
    chk({tag, "_medida_kept"}, 32'(medida), 32'(exp_medida));
    repeat (2) @(negedge clock);
    #1;
    chk({tag, "_pronto_once"}, 32'(pronto_cnt - p0), 32'd1);
  endtask

  initial begin
    int lat, p0, t0, w;
    reset = 1'b1; medir = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    chk("reset_state", 32'(db_estado), 32'd0);
    chk("reset_trigger", 32'(trigger), 32'd0);
    chk("reset_pronto", 32'(pronto), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_medida", 32'(medida), 32'h000);
    medir = 1'b0;
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    chk("no_trigger_without_medir", 32'(trig_rises), 32'd0);

    measure(1000, "nominal_100cm");
    measure(1004, "truncate_100cm");
    measure(746, "round_up_75cm");
    measure(744, "round_down_74cm");
    no_echo(1'b0, "timeout");
    measure($urandom_range(1, 1500), "clears_timeout");
    for (int i = 0; i < 8; i++) measure($urandom_range(1, 1500), "random");
    no_echo(1'b1, "echo_high_on_entry");
    measure(10200, "saturate_999");

    // medir held high: back-to-back measurements each starting from PREPARA
    medir = 1'b1;
    for (int m = 0; m < 2; m++) begin
      w  = safe_width($urandom_range(50, 800));
      p0 = pronto_cnt;
      wait_trigger(1'b0);
      echo_pulse(w, 1'b0, lat);
      if (m == 1) medir = 1'b0;
      exp_medida = to_bcd(model_cm(w - 1));
      chk("held_pronto_latency", 32'(lat >= 1 && lat <= 4), 32'd1);
      chk("held_medida", 32'(medida), 32'(exp_medida));
      @(negedge clock);
      chk("held_next_inicial", 32'(db_estado), 32'd0);
      @(negedge clock);
      chk("held_next_state", 32'(db_estado), (m == 0) ? 32'd1 : 32'd0);
    end
    repeat (5) @(negedge clock);
    chk("held_release_idle", 32'(db_estado), 32'd0);

    // reset in the middle of a measurement, with timeout and medida both nonzero
    no_echo(1'b0, "pre_reset_timeout");
    pulse_medir();
    wait_trigger(1'b0);
    echo = 1'b1;
    repeat (30) @(negedge clock);
    chk("mid_mede_state", 32'(db_estado), 32'd4);
    p0 = pronto_cnt;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_state", 32'(db_estado), 32'd0);
    chk("mid_reset_trigger", 32'(trigger), 32'd0);
    chk("mid_reset_pronto", 32'(pronto), 32'd0);
    chk("mid_reset_timeout", 32'(timeout), 32'd0);
    chk("mid_reset_medida", 32'(medida), 32'h000);
    exp_medida = 12'h000; exp_timeout = 1'b0;
    echo = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    t0 = trig_rises;
    repeat (20) @(negedge clock);
    #1;
    chk("post_reset_no_trigger", 32'(trig_rises - t0), 32'd0);
    chk("post_reset_no_pronto", 32'(pronto_cnt - p0), 32'd0);
    measure($urandom_range(100, 900), "after_reset");

    chk("outputs_change_only_in_final", 32'(hold_viol), 32'd0);
    chk("trigger_only_in_trigger_state", 32'(trig_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
